// File: rtl/ps2_keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: rx FSM states,
// STATUS register bit positions and register addresses.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int STAT_NONEMPTY = 7;
    localparam int STAT_FULL     = 6;
    localparam int STAT_OVF      = 5;
    localparam int STAT_PAR      = 4;
    localparam int STAT_FRM      = 3;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

endpackage

// File: rtl/ps2_keyboard_if.sv
// CPU-side register strobes of the keyboard (chip-select already applied).
// The shared data byte is a tri-state net and stays a plain inout port.
interface ps2_keyboard_if;

    logic address;
    logic write;
    logic read;

    modport master (output address, output write, output read);
    modport slave  (input  address, input  write, input  read);

endinterface

// File: rtl/ps2_keyboard_byte_fifo.sv
// Byte FIFO of depth 2**FIFO_AW with registered pointers and a combinational head.
// A pop in the same cycle frees a slot, so a push into a full FIFO then succeeds.
module byte_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [7:0]       din_i,
    input  logic             pop_i,
    output logic [7:0]       head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [FIFO_AW:0] count_o,
    output logic             push_ok_o
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               pop_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok_o = push_i && (!full_o || pop_ok);
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // NOTE: storage has no reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wr_ptr_q] <= din_i;
    end

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        case ({push_ok_o, pop_ok})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_o) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop_ok)    rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// Memory-mapped PS/2 keyboard receiver: frames -> byte FIFO -> DATA/STATUS registers.
// Define KEYBOARD_IRQ_EN to add the registered irq output.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_AW        = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic          clk,
    input  logic          reset,
    ps2_keyboard_if.slave bus,
    inout  wire  [7:0]    data_bus,
    input  logic          ps2_clk,
    input  logic          ps2_data
`ifdef KEYBOARD_IRQ_EN
    ,
    output logic          irq
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [2:0]       ps2c_q;
    logic [1:0]       ps2d_q;
    logic             strobe, rx_bit, tmo_hit;
    rx_state_t        state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             push, par_set, frm_set, frame_odd;

    logic [7:0]       head, status, rd_val;
    logic             full, empty, push_ok, pop;
    logic [FIFO_AW:0] count;
    logic             ovf_q, par_err_q, frm_err_q, rd_data_q;
    logic [2:0]       clr;
    logic             unused_wr_bits;

    // Third ps2_clk flop holds the previous synced level for falling-edge detect.
    assign strobe    = ps2c_q[2] & ~ps2c_q[1];
    assign rx_bit    = ps2d_q[1];
    assign frame_odd = ^{shift_q, par_q};
    assign tmo_hit   = (state_q != IDLE) && !strobe
                       && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_q    <= '1;
            ps2d_q    <= '1;
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            ps2c_q    <= {ps2c_q[1:0], ps2_clk};
            ps2d_q    <= {ps2d_q[0], ps2_data};
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        tmo_d     = (strobe || state_q == IDLE) ? '0 : tmo_q + TMO_W'(1);
        if (tmo_hit) begin
            state_d = IDLE;
        end else if (strobe) begin
            case (state_q)
                IDLE: begin
                    if (!rx_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {rx_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = rx_bit;
                    state_d = STOP;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        push    = 1'b0;
        par_set = 1'b0;
        frm_set = 1'b0;
        if (tmo_hit) begin
            frm_set = 1'b1;
        end else if (strobe && state_q == STOP) begin
            frm_set = !rx_bit;
            par_set = !frame_odd;
            push    = rx_bit && frame_odd;
        end
    end

    byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (push),
        .din_i    (shift_q),
        .pop_i    (pop),
        .head_o   (head),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count),
        .push_ok_o(push_ok)
    );

    // One pop per DATA strobe, taken when read drops.
    assign pop = rd_data_q && !bus.read;
    assign clr = (bus.write && bus.address == REG_STATUS) ? data_bus[5:3] : 3'b000;
    assign unused_wr_bits = ^{data_bus[7:6], data_bus[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= 1'b0;
            ovf_q     <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            rd_data_q <= bus.read && (bus.address == REG_DATA);
            ovf_q     <= (push && !push_ok) || (ovf_q && !clr[2]);
            par_err_q <= par_set || (par_err_q && !clr[1]);
            frm_err_q <= frm_set || (frm_err_q && !clr[0]);
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_NONEMPTY] = (count != '0);
        status[STAT_FULL]     = full;
        status[STAT_OVF]      = ovf_q;
        status[STAT_PAR]      = par_err_q;
        status[STAT_FRM]      = frm_err_q;
        rd_val                = status;
        if (bus.address == REG_DATA) rd_val = empty ? 8'h00 : head;
    end

    assign data_bus = bus.read ? rd_val : 8'hzz;

`ifdef KEYBOARD_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= !empty || ovf_q || par_err_q || frm_err_q;
    end
`endif

endmodule
